// File: rtl/sound_sequencer.sv
// Priority-arbitrated tune player: edge-detected requests start fixed note sequences,
// timed by a tick prescaler, emitted as 4-bit note codes with a tone-generator enable.
module sound_sequencer #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned NOTE_TICKS = 150,
    parameter int unsigned GAP_TICKS  = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable_EXPLOSION_SOUND_START,
    input  logic       enable_LOSER,
    input  logic       enable_ENDGAME_INTRO_1,
    input  logic       mute,
    output logic [3:0] freq_code,
    output logic       sound_en,
    output logic [1:0] tune_id,
    output logic       busy
);

    localparam int unsigned MaxNotes = 6;
    localparam int unsigned NoteW    = $clog2(MaxNotes);
    localparam int unsigned DivW     = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
    localparam int unsigned TickMax  = NOTE_TICKS > GAP_TICKS ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned TickW    = $clog2(TickMax > 1 ? TickMax : 2);

    localparam int unsigned GapLastInt = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

    localparam logic [DivW-1:0]  DivLast  = DivW'(TICK_DIV - 1);
    localparam logic [TickW-1:0] NoteLast = TickW'(NOTE_TICKS - 1);
    localparam logic [TickW-1:0] GapLast  = TickW'(GapLastInt);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e           state_q, state_d;
    logic [1:0]       tune_q, tune_d;
    logic [NoteW-1:0] note_q, note_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       req_q;

    logic [2:0] req;
    logic [2:0] req_edge;
    logic [1:0] new_prio;
    logic       tick_end;

    function automatic logic [3:0] rom_note(input logic [1:0] tune, input logic [NoteW-1:0] idx);
        logic [3:0] n;
        n = 4'd0;
        case (tune)
            2'd1: case (idx)
                3'd0: n = 4'd12;
                3'd1: n = 4'd8;
                3'd2: n = 4'd4;
                default: n = 4'd0;
            endcase
            2'd2: case (idx)
                3'd0: n = 4'd9;
                3'd1: n = 4'd7;
                3'd2: n = 4'd5;
                3'd3: n = 4'd1;
                default: n = 4'd0;
            endcase
            2'd3: case (idx)
                3'd0: n = 4'd1;
                3'd1: n = 4'd3;
                3'd2: n = 4'd5;
                3'd3: n = 4'd8;
                3'd4: n = 4'd10;
                3'd5: n = 4'd12;
                default: n = 4'd0;
            endcase
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic [NoteW-1:0] last_idx(input logic [1:0] tune);
        logic [NoteW-1:0] l;
        case (tune)
            2'd1:    l = 3'd2;
            2'd2:    l = 3'd3;
            2'd3:    l = 3'd5;
            default: l = 3'd0;
        endcase
        return l;
    endfunction

    assign req      = {enable_ENDGAME_INTRO_1, enable_LOSER, enable_EXPLOSION_SOUND_START};
    assign req_edge = req & ~req_q;
    assign tick_end = (div_q == DivLast);

    always_comb begin
        new_prio = 2'd0;
        if (req_edge[2]) begin
            new_prio = 2'd3;
        end else if (req_edge[1]) begin
            new_prio = 2'd2;
        end else if (req_edge[0]) begin
            new_prio = 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        tune_d  = tune_q;
        note_d  = note_q;
        div_d   = div_q;
        tick_d  = tick_q;
        // tune_q is 0 in idle, so this one compare covers both start and preemption
        if (new_prio > tune_q) begin
            state_d = StPlay;
            tune_d  = new_prio;
            note_d  = '0;
            div_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                StPlay: begin
                    if (!tick_end) begin
                        div_d = div_q + 1'b1;
                    end else begin
                        div_d = '0;
                        if (tick_q != NoteLast) begin
                            tick_d = tick_q + 1'b1;
                        end else begin
                            tick_d = '0;
                            if (note_q == last_idx(tune_q)) begin
                                state_d = StIdle;
                                tune_d  = 2'd0;
                                note_d  = '0;
                            end else if (GAP_TICKS == 0) begin
                                note_d = note_q + 1'b1;
                            end else begin
                                state_d = StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    if (!tick_end) begin
                        div_d = div_q + 1'b1;
                    end else begin
                        div_d = '0;
                        if (tick_q != GapLast) begin
                            tick_d = tick_q + 1'b1;
                        end else begin
                            tick_d  = '0;
                            state_d = StPlay;
                            note_d  = note_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            tune_q  <= 2'd0;
            note_q  <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            req_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            tune_q  <= tune_d;
            note_q  <= note_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            req_q   <= req;
        end
    end

    always_comb begin
        freq_code = 4'd0;
        sound_en  = 1'b0;
        busy      = (state_q != StIdle);
        tune_id   = tune_q;
        if (state_q == StPlay) begin
            freq_code = rom_note(tune_q, note_q);
            sound_en  = ~mute;
        end
    end

endmodule
